// File: rtl/store_drain_unit.sv
// Store drain unit: commits store-queue head stores to memory as 64-bit blocks,
// using read-modify-write for partial stores.
module store_drain_unit #(
  parameter int unsigned TAG_WIDTH    = 4,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned ROB_WIDTH    = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sq_req_valid,
  input  logic [31:0]          sq_req_addr,
  input  logic [1:0]           sq_req_size,
  input  logic [63:0]          sq_req_data,
  input  logic [ROB_WIDTH-1:0] sq_req_rob_idx,
  output logic                 sq_req_accept,
  output logic [1:0]           proc2mem_command,
  output logic [31:0]          proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  input  logic [TAG_WIDTH-1:0] mem2proc_transaction_tag,
  input  logic [TAG_WIDTH-1:0] mem2proc_data_tag,
  input  logic [63:0]          mem2proc_data,
  output logic                 store_done_valid,
  output logic [ROB_WIDTH-1:0] store_done_rob_idx,
  output logic                 misalign_err,
  output logic                 busy,
  output logic [31:0]          busy_block_addr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic [31:0]          block_addr_q, block_addr_d;
  logic [ROB_WIDTH-1:0] rob_q, rob_d;
  logic [63:0]          wmask_q, wmask_d;
  logic [63:0]          shifted_q, shifted_d;
  logic [63:0]          merged_q, merged_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 misalign_q, misalign_d;

  logic [2:0]  off;
  logic [7:0]  base_mask;
  logic [7:0]  req_mask;
  logic [63:0] req_wmask;
  logic [63:0] req_shifted;
  logic        misaligned;
  logic        fire;
  logic        tag_ok;

  assign off    = sq_req_addr[2:0];
  assign fire   = sq_req_valid && sq_req_accept;
  assign tag_ok = (mem2proc_transaction_tag != '0);

  always_comb begin
    base_mask  = 8'h01;
    misaligned = 1'b0;
    unique case (sq_req_size)
      2'd0: begin base_mask = 8'h01; misaligned = 1'b0;          end
      2'd1: begin base_mask = 8'h03; misaligned = off[0];        end
      2'd2: begin base_mask = 8'h0f; misaligned = |off[1:0];     end
      2'd3: begin base_mask = 8'hff; misaligned = |off;          end
      default: ;
    endcase
    req_mask = base_mask << off;
    for (int i = 0; i < 8; i++) begin
      req_wmask[8*i +: 8] = {8{req_mask[i]}};
    end
    req_shifted = (sq_req_data << {off, 3'b000}) & req_wmask;
  end

  always_comb begin
    state_d      = state_q;
    block_addr_d = block_addr_q;
    rob_d        = rob_q;
    wmask_d      = wmask_q;
    shifted_d    = shifted_q;
    merged_d     = merged_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    misalign_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            block_addr_d = {sq_req_addr[31:3], 3'b000};
            rob_d        = sq_req_rob_idx;
            wmask_d      = req_wmask;
            shifted_d    = req_shifted;
            // A full-block store needs no read; its merged value is the data itself.
            merged_d     = req_shifted;
            state_d      = (sq_req_size == 2'd3) ? WR_REQ : RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (tag_ok) begin
          tag_d   = mem2proc_transaction_tag;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem2proc_data_tag == tag_q) begin
          merged_d = (mem2proc_data & ~wmask_q) | (shifted_q & wmask_q);
          state_d  = WR_REQ;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Give up on this tag; any late return of it no longer matches.
          tag_d   = '0;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        if (tag_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      block_addr_q <= '0;
      rob_q        <= '0;
      wmask_q      <= '0;
      shifted_q    <= '0;
      merged_q     <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      block_addr_q <= block_addr_d;
      rob_q        <= rob_d;
      wmask_q      <= wmask_d;
      shifted_q    <= shifted_d;
      merged_q     <= merged_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      misalign_q   <= misalign_d;
    end
  end

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    unique case (state_q)
      RD_REQ: begin
        proc2mem_command = MEM_LOAD;
        proc2mem_addr    = block_addr_q;
      end
      WR_REQ: begin
        proc2mem_command = MEM_STORE;
        proc2mem_addr    = block_addr_q;
        proc2mem_data    = merged_q;
      end
      default: ;
    endcase
  end

  assign sq_req_accept      = reset && (state_q == IDLE);
  assign store_done_valid   = (state_q == WR_REQ) && tag_ok;
  assign store_done_rob_idx = store_done_valid ? rob_q : '0;
  assign misalign_err       = misalign_q;
  assign busy               = (state_q != IDLE);
  assign busy_block_addr    = busy ? block_addr_q : '0;

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed self-checking bench for store_drain_unit with hand-computed expectations.
module tb_store_drain_unit;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  logic        clock;
  logic        reset;
  logic        sq_req_valid;
  logic [31:0] sq_req_addr;
  logic [1:0]  sq_req_size;
  logic [63:0] sq_req_data;
  logic [4:0]  sq_req_rob_idx;
  logic        sq_req_accept;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [3:0]  mem2proc_data_tag;
  logic [63:0] mem2proc_data;
  logic        store_done_valid;
  logic [4:0]  store_done_rob_idx;
  logic        misalign_err;
  logic        busy;
  logic [31:0] busy_block_addr;

  int n_tests;
  int n_fail;

  store_drain_unit #(
    .TAG_WIDTH    (4),
    .WAIT_TIMEOUT (4),
    .ROB_WIDTH    (5)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .sq_req_valid             (sq_req_valid),
    .sq_req_addr              (sq_req_addr),
    .sq_req_size              (sq_req_size),
    .sq_req_data              (sq_req_data),
    .sq_req_rob_idx           (sq_req_rob_idx),
    .sq_req_accept            (sq_req_accept),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .mem2proc_data            (mem2proc_data),
    .store_done_valid         (store_done_valid),
    .store_done_rob_idx       (store_done_rob_idx),
    .misalign_err             (misalign_err),
    .busy                     (busy),
    .busy_block_addr          (busy_block_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow after settling.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d,
                      input logic [4:0] r);
    sq_req_valid   = 1'b1;
    sq_req_addr    = a;
    sq_req_size    = s;
    sq_req_data    = d;
    sq_req_rob_idx = r;
  endtask

  initial begin
    n_tests                  = 0;
    n_fail                   = 0;
    reset                    = 1'b0;
    sq_req_valid             = 1'b0;
    sq_req_addr              = '0;
    sq_req_size              = '0;
    sq_req_data              = '0;
    sq_req_rob_idx           = '0;
    mem2proc_transaction_tag = '0;
    mem2proc_data_tag        = '0;
    mem2proc_data            = '0;

    // Outputs while held in reset
    step(); step(); settle();
    check_eq("rst_accept", 64'(sq_req_accept), 64'd0);
    check_eq("rst_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(store_done_valid), 64'd0);
    step(); reset = 1'b1; settle();
    check_eq("idle_accept", 64'(sq_req_accept), 64'd1);

    // Reset mid RD_WAIT with tag 3 latched
    step(); send(32'h1003, 2'd0, 64'hAB, 5'd1); settle();
    check_eq("r_accept", 64'(sq_req_accept), 64'd1);
    step(); sq_req_valid = 1'b0; mem2proc_transaction_tag = 4'd3; settle();
    check_eq("r_cmd_load", 64'(proc2mem_command), 64'(MEM_LOAD));
    check_eq("r_busy_addr", 64'(busy_block_addr), 64'h1000);
    step(); mem2proc_transaction_tag = 4'd0; settle();
    check_eq("r_wait_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check_eq("r_wait_busy", 64'(busy), 64'd1);
    reset = 1'b0; settle();
    check_eq("r_async_busy", 64'(busy), 64'd0);
    check_eq("r_async_addr", 64'(busy_block_addr), 64'd0);
    check_eq("r_async_acc", 64'(sq_req_accept), 64'd0);
    step(); reset = 1'b1; settle();
    check_eq("r_rel_accept", 64'(sq_req_accept), 64'd1);
    mem2proc_data_tag = 4'd3; mem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); mem2proc_data_tag = 4'd0; mem2proc_data = '0; settle();
    check_eq("r_stale_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check_eq("r_stale_busy", 64'(busy), 64'd0);
    check_eq("r_stale_done", 64'(store_done_valid), 64'd0);

    // BYTE store read-modify-write
    step(); send(32'h1003, 2'd0, 64'hAB, 5'd9); settle();
    check_eq("b_accept", 64'(sq_req_accept), 64'd1);
    step(); sq_req_valid = 1'b0; mem2proc_transaction_tag = 4'd3; settle();
    check_eq("b_cmd_load", 64'(proc2mem_command), 64'(MEM_LOAD));
    check_eq("b_load_addr", 64'(proc2mem_addr), 64'h1000);
    step(); mem2proc_transaction_tag = 4'd0;
    mem2proc_data_tag = 4'd3; mem2proc_data = 64'h1122334455667788; settle();
    check_eq("b_wait_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    step(); mem2proc_data_tag = 4'd0; mem2proc_data = '0;
    mem2proc_transaction_tag = 4'd4; settle();
    check_eq("b_cmd_store", 64'(proc2mem_command), 64'(MEM_STORE));
    check_eq("b_st_addr", 64'(proc2mem_addr), 64'h1000);
    check_eq("b_st_data", proc2mem_data, 64'h11223344AB667788);
    check_eq("b_done", 64'(store_done_valid), 64'd1);
    check_eq("b_done_rob", 64'(store_done_rob_idx), 64'd9);
    step(); mem2proc_transaction_tag = 4'd0; settle();
    check_eq("b_post_done", 64'(store_done_valid), 64'd0);
    check_eq("b_post_acc", 64'(sq_req_accept), 64'd1);

    // DOUBLE store: no read, done one cycle after accept
    send(32'h2000, 2'd3, 64'hDEADBEEFCAFEF00D, 5'd2); settle();
    check_eq("d_accept", 64'(sq_req_accept), 64'd1);
    step(); sq_req_valid = 1'b0; mem2proc_transaction_tag = 4'd5; settle();
    check_eq("d_cmd_store", 64'(proc2mem_command), 64'(MEM_STORE));
    check_eq("d_st_addr", 64'(proc2mem_addr), 64'h2000);
    check_eq("d_st_data", proc2mem_data, 64'hDEADBEEFCAFEF00D);
    check_eq("d_done", 64'(store_done_valid), 64'd1);
    check_eq("d_done_rob", 64'(store_done_rob_idx), 64'd2);
    check_eq("d_busy_addr", 64'(busy_block_addr), 64'h2000);
    step(); mem2proc_transaction_tag = 4'd0; settle();
    check_eq("d_post_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check_eq("d_post_acc", 64'(sq_req_accept), 64'd1);

    // HALF store with rejected loads and an ignored foreign data tag
    send(32'h3006, 2'd1, 64'h1234, 5'd3);
    step(); sq_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("h_retry_load", 64'(proc2mem_command), 64'(MEM_LOAD));
      step();
    end
    mem2proc_transaction_tag = 4'd7; settle();
    check_eq("h_load_ok", 64'(proc2mem_command), 64'(MEM_LOAD));
    check_eq("h_load_addr", 64'(proc2mem_addr), 64'h3000);
    step(); mem2proc_transaction_tag = 4'd0;
    mem2proc_data_tag = 4'd2; mem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF; settle();
    check_eq("h_wait_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    step(); mem2proc_data_tag = 4'd7; mem2proc_data = '0; settle();
    check_eq("h_foreign_ign", 64'(proc2mem_command), 64'(MEM_NONE));
    step(); mem2proc_data_tag = 4'd0; mem2proc_transaction_tag = 4'd1; settle();
    check_eq("h_cmd_store", 64'(proc2mem_command), 64'(MEM_STORE));
    check_eq("h_st_data", proc2mem_data, 64'h1234000000000000);
    check_eq("h_done_rob", 64'(store_done_rob_idx), 64'd3);
    step(); mem2proc_transaction_tag = 4'd0;

    // Misaligned WORD is dropped
    send(32'h1002, 2'd2, 64'h55667788, 5'd4); settle();
    check_eq("m_accept", 64'(sq_req_accept), 64'd1);
    step(); sq_req_valid = 1'b0; settle();
    check_eq("m_err", 64'(misalign_err), 64'd1);
    check_eq("m_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check_eq("m_accept2", 64'(sq_req_accept), 64'd1);
    check_eq("m_busy", 64'(busy), 64'd0);
    step(); settle();
    check_eq("m_err_pulse", 64'(misalign_err), 64'd0);
    check_eq("m_no_done", 64'(store_done_valid), 64'd0);
    check_eq("m_cmd2", 64'(proc2mem_command), 64'(MEM_NONE));

    // Read tag never returns: re-issue after 4 RD_WAIT cycles
    send(32'h4001, 2'd0, 64'h5A, 5'd6);
    step(); sq_req_valid = 1'b0; mem2proc_transaction_tag = 4'd2; settle();
    check_eq("t_load1", 64'(proc2mem_command), 64'(MEM_LOAD));
    step(); mem2proc_transaction_tag = 4'd0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("t_waiting", 64'(proc2mem_command), 64'(MEM_NONE));
      step();
    end
    settle();
    check_eq("t_reissue", 64'(proc2mem_command), 64'(MEM_LOAD));
    check_eq("t_reissue_addr", 64'(proc2mem_addr), 64'h4000);
    mem2proc_transaction_tag = 4'd8;
    step(); mem2proc_transaction_tag = 4'd0;
    mem2proc_data_tag = 4'd2; mem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF; settle();
    check_eq("t_wait2", 64'(proc2mem_command), 64'(MEM_NONE));
    step(); mem2proc_data_tag = 4'd8; mem2proc_data = '0; settle();
    check_eq("t_stale_ign", 64'(proc2mem_command), 64'(MEM_NONE));
    step(); mem2proc_data_tag = 4'd0; mem2proc_transaction_tag = 4'd1; settle();
    check_eq("t_cmd_store", 64'(proc2mem_command), 64'(MEM_STORE));
    check_eq("t_st_data", proc2mem_data, 64'h5A00);
    check_eq("t_done", 64'(store_done_valid), 64'd1);
    check_eq("t_done_rob", 64'(store_done_rob_idx), 64'd6);
    step(); mem2proc_transaction_tag = 4'd0; settle();
    check_eq("t_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
